axis_fifo: RTL and testbench

AXIS_FIFO -- requirements
Module: axis_fifo

---
 rtl/axis_fifo_if.sv | 30 +++
 rtl/axis_fifo.sv | 107 ++++++++++
 tb/tb_axis_fifo.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/axis_fifo_if.sv
// rtl/axis_fifo_if.sv - AXI-Stream style interface ifc_axis carrying clk/rst plus one stream.
interface ifc_axis #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1
) (
  input logic clk,
  input logic rst
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tready;

  modport sink (
    input  clk, rst, tdata, tkeep, tlast, tid, tdest, tuser, tvalid,
    output tready
  );

  modport source (
    input  tready,
    output tdata, tkeep, tlast, tid, tdest, tuser, tvalid
  );
endinterface

// File: rtl/axis_fifo.sv
// rtl/axis_fifo.sv - first-word-fall-through AXI-Stream FIFO with optional sideband storage.
// Define AXIS_FIFO_STATUS_EN to add status_count/status_full/status_empty outputs.
module axis_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int KEEP_ENABLE = 0,
  parameter int KEEP_WIDTH  = 1,
  parameter int LAST_ENABLE = 1,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 1,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 1,
  parameter int USER_ENABLE = 0,
  parameter int USER_WIDTH  = 1
) (
  ifc_axis.sink   s_axis_ifc,
  ifc_axis.source m_axis_ifc
`ifdef AXIS_FIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0] status_count,
  output logic                   status_full,
  output logic                   status_empty
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int KO = DATA_WIDTH;
  localparam int LO = KO + KEEP_WIDTH;
  localparam int IO = LO + 1;
  localparam int DO = IO + ID_WIDTH;
  localparam int UO = DO + DEST_WIDTH;
  localparam int WW = UO + USER_WIDTH;

  logic clk;
  logic rst;
  assign clk = s_axis_ifc.clk;
  assign rst = s_axis_ifc.rst;

  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WW-1:0] mem_q [DEPTH];
  logic [WW-1:0] wr_word, rd_word;
  logic          full, empty, s_ready, m_valid, wr_en, rd_en;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (pointers equal).
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign s_ready = !full && !rst;
  assign m_valid = !empty && !rst;
  assign wr_en   = s_axis_ifc.tvalid && s_ready;
  assign rd_en   = m_valid && m_axis_ifc.tready;

  assign s_axis_ifc.tready = s_ready;
  assign m_axis_ifc.tvalid = m_valid;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign wr_word = {s_axis_ifc.tuser, s_axis_ifc.tdest, s_axis_ifc.tid,
                    s_axis_ifc.tlast, s_axis_ifc.tkeep, s_axis_ifc.tdata};

  // Storage needs no reset; disabled fields are never observed and get pruned.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
    end
  end

  assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

  assign m_axis_ifc.tdata = rd_word[DATA_WIDTH-1:0];
  assign m_axis_ifc.tkeep = (KEEP_ENABLE != 0) ? rd_word[KO +: KEEP_WIDTH] : {KEEP_WIDTH{1'b1}};
  assign m_axis_ifc.tlast = (LAST_ENABLE != 0) ? rd_word[LO] : 1'b1;
  assign m_axis_ifc.tid   = (ID_ENABLE != 0)   ? rd_word[IO +: ID_WIDTH]   : '0;
  assign m_axis_ifc.tdest = (DEST_ENABLE != 0) ? rd_word[DO +: DEST_WIDTH] : '0;
  assign m_axis_ifc.tuser = (USER_ENABLE != 0) ? rd_word[UO +: USER_WIDTH] : '0;

`ifdef AXIS_FIFO_STATUS_EN
  logic [AW:0] count_q, count_d;

  always_comb begin
    count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign status_count = rst ? '0 : count_q;
  assign status_full  = !rst && (count_q == (AW+1)'(DEPTH));
  assign status_empty = rst || (count_q == '0);
`endif
endmodule

// File: tb/tb_axis_fifo.sv
// tb/tb_axis_fifo.sv - randomized bench for axis_fifo against a queue-based reference model.
module tb_axis_fifo;
  localparam int DW    = 128;
  localparam int DEPTH = 16;
  localparam int NWORD = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifc_axis #(.DATA_WIDTH(DW)) s_if (.clk(clk), .rst(rst));
  ifc_axis #(.DATA_WIDTH(DW)) m_if (.clk(clk), .rst(rst));

`ifdef AXIS_FIFO_STATUS_EN
  logic [$clog2(DEPTH):0] status_count;
  logic                   status_full;
  logic                   status_empty;
`endif

  axis_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .s_axis_ifc  (s_if),
    .m_axis_ifc  (m_if)
`ifdef AXIS_FIFO_STATUS_EN
    ,
    .status_count(status_count),
    .status_full (status_full),
    .status_empty(status_empty)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t model_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    n_pop = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge: drive, compare, then advance the model across the rising edge.
  task automatic cycle(input logic r, input logic sv, input logic [DW-1:0] sd, input logic sl,
                       input logic mr, output logic acc);
    logic con;
    int   sz;
    rst         = r;
    s_if.tvalid = sv;
    s_if.tdata  = sd;
    s_if.tlast  = sl;
    s_if.tkeep  = 1'($urandom);
    s_if.tid    = 1'($urandom);
    s_if.tdest  = 1'($urandom);
    s_if.tuser  = 1'($urandom);
    m_if.tready = mr;
    #1;
    sz = model_q.size();
    check("s_tready", 128'(s_if.tready), 128'(!r && sz < DEPTH));
    check("m_tvalid", 128'(m_if.tvalid), 128'(!r && sz > 0));
    if (!r && sz > 0) begin
      check("m_tdata", m_if.tdata, model_q[0].d);
      check("m_tlast", 128'(m_if.tlast), 128'(model_q[0].l));
      check("m_side", 128'({m_if.tkeep, m_if.tid, m_if.tdest, m_if.tuser}), 128'(4'b1000));
    end
`ifdef AXIS_FIFO_STATUS_EN
    check("st_count", 128'(status_count), r ? 128'(0) : 128'(sz));
    check("st_full", 128'(status_full), 128'(!r && sz == DEPTH));
    check("st_empty", 128'(status_empty), 128'(r || sz == 0));
`endif
    acc = sv && !r && sz < DEPTH;
    con = mr && !r && sz > 0;
    @(posedge clk);
    if (r) begin
      model_q.delete();
    end else begin
      if (con) begin
        void'(model_q.pop_front());
        n_pop++;
      end
      if (acc) model_q.push_back('{d: sd, l: sl});
    end
    @(negedge clk);
  endtask

  initial begin
    logic          acc;
    logic [DW-1:0] cur;
    int            idx;
    int            pops0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tkeep  = '0;
    s_if.tid    = '0;
    s_if.tdest  = '0;
    s_if.tuser  = '0;
    m_if.tready = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) cycle(1, 0, '0, 0, 0, acc);
    cycle(0, 0, '0, 0, 0, acc);

    cycle(0, 1, 128'h01, 0, 1, acc);
    check("first_acc", 128'(acc), 128'(1));
    cycle(0, 0, '0, 0, 1, acc);
    cycle(0, 0, '0, 0, 1, acc);

    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 128'(i), 0, 0, acc);
    cycle(0, 1, 128'(DEPTH), 0, 0, acc);
    check("full_reject", 128'(acc), 128'(0));
    cycle(0, 1, 128'h99, 0, 1, acc);
    check("full_rd_wr", 128'(acc), 128'(0));
    check("full_after", 128'(model_q.size()), 128'(DEPTH - 1));
    for (int c = 0; c < 40 && model_q.size() > 0; c++) cycle(0, 0, '0, 0, 1, acc);
    check("drain_empty", 128'(model_q.size()), 128'(0));

    idx   = 0;
    pops0 = n_pop;
    cur   = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 40000 && idx < NWORD; c++) begin
      cycle(0, $urandom_range(9, 0) < 7, cur, idx == NWORD - 1, $urandom_range(9, 0) < 6, acc);
      if (acc) begin
        idx++;
        cur = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    check("rand_sent", 128'(idx), 128'(NWORD));
    for (int c = 0; c < 100 && model_q.size() > 0; c++) cycle(0, 0, '0, 0, 1, acc);
    check("rand_recv", 128'(n_pop - pops0), 128'(NWORD));

    for (int i = 0; i < 5; i++) cycle(0, 1, 128'(8'h50 + i), 0, 0, acc);
    check("pre_rst_cnt", 128'(model_q.size()), 128'(5));
    cycle(1, 0, '0, 0, 0, acc);
    cycle(0, 1, 128'hAA, 1, 0, acc);
    cycle(0, 0, '0, 0, 1, acc);
    cycle(0, 0, '0, 0, 1, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
